// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 3;

  typedef logic port_id_t;

  typedef struct packed {
    logic     vld;
    port_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the RAM arbiter: request handshake plus read response.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_arb_pkg::DATA_W
);

  logic              valid;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output valid, wren, addr, data,
    input  ready, rsp_valid, rsp_data
  );

  modport slave (
    input  valid, wren, addr, data,
    output ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant resets to port 1 so port 0 wins the first contest.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_id_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_o = 2'b00;
    if (!reset) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    last_grant_d = last_grant_q;
    if (gnt_o != 2'b00) last_grant_d = gnt_o[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters, one access per clock,
// with read responses routed back to the issuing port RD_LAT cycles after acceptance.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_arb_pkg::DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  ram_port_arbiter_if.slave req0,
  ram_port_arbiter_if.slave req1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  import ram_arb_pkg::*;

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("ram_port_arbiter: RD_LAT must be 1 or 2");
  end

  logic [1:0] gnt;
  rd_tag_t    tag_q [RD_LAT];
  rd_tag_t    tag_d [RD_LAT];
  rd_tag_t    tag_out;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i ({req1.valid, req0.valid}),
    .gnt_o (gnt)
  );

  assign req0.ready = gnt[0];
  assign req1.ready = gnt[1];

  // Idle cycles still present port 0's address; only wren matters then.
  always_comb begin
    ram_address = req0.addr;
    ram_data    = req0.data;
    ram_wren    = 1'b0;
    if (gnt[1]) begin
      ram_address = req1.addr;
      ram_data    = req1.data;
      ram_wren    = req1.wren;
    end else if (gnt[0]) begin
      ram_wren    = req0.wren;
    end
  end

  always_comb begin
    tag_d[0].vld = (gnt != 2'b00) && !ram_wren;
    tag_d[0].id  = gnt[1];
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  always_comb begin
    req0.rsp_valid = tag_out.vld && (tag_out.id == 1'b0);
    req1.rsp_valid = tag_out.vld && (tag_out.id == 1'b1);
    req0.rsp_data  = req0.rsp_valid ? ram_q : '0;
    req1.rsp_data  = req1.rsp_valid ? ram_q : '0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: two arbiter builds (RD_LAT 1 and 2), each in front of a behavioural RAM.
module tb_ram_port_arbiter;

  logic clk;
  logic reset;
  logic load;

  int n_vec = 0;
  int n_err = 0;

  ram_port_arbiter_if a0 ();
  ram_port_arbiter_if a1 ();
  ram_port_arbiter_if b0 ();
  ram_port_arbiter_if b1 ();

  logic [4:0] addr1, addr2;
  logic [2:0] data1, data2, q1, q2, q2a;
  logic       wren1, wren2;
  logic [2:0] mem1 [32];
  logic [2:0] mem2 [32];

  ram_port_arbiter #(.RD_LAT(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .req0        (a0),
    .req1        (a1),
    .ram_address (addr1),
    .ram_data    (data1),
    .ram_wren    (wren1),
    .ram_q       (q1)
  );

  ram_port_arbiter #(.RD_LAT(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .req0        (b0),
    .req1        (b1),
    .ram_address (addr2),
    .ram_data    (data2),
    .ram_wren    (wren2),
    .ram_q       (q2)
  );

  function automatic logic [2:0] f1(input int i);
    logic [2:0] lo;
    lo = 3'(i);
    return lo ^ 3'b011;
  endfunction

  function automatic logic [2:0] f2(input int i);
    logic [2:0] lo;
    lo = 3'(i);
    return ~lo;
  endfunction

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 32; i++) mem1[i] <= f1(i);
    else if (wren1) mem1[addr1] <= data1;
    q1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 32; i++) mem2[i] <= f2(i);
    else if (wren2) mem2[addr2] <= data2;
    q2a <= mem2[addr2];
    q2  <= q2a;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input int p, input logic v, input logic w, input logic [4:0] ad,
                       input logic [2:0] d);
    if (p == 0) begin
      a0.valid = v; a0.wren = w; a0.addr = ad; a0.data = d;
    end else begin
      a1.valid = v; a1.wren = w; a1.addr = ad; a1.data = d;
    end
  endtask

  task automatic drv_b(input int p, input logic v, input logic w, input logic [4:0] ad,
                       input logic [2:0] d);
    if (p == 0) begin
      b0.valid = v; b0.wren = w; b0.addr = ad; b0.data = d;
    end else begin
      b1.valid = v; b1.wren = w; b1.addr = ad; b1.data = d;
    end
  endtask

  int exp_g;
  int prev_g;

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    // 1: reset holds everything off even with both ports requesting
    drv_a(0, 1'b1, 1'b1, 5'd5, 3'b101);
    drv_a(1, 1'b1, 1'b0, 5'd2, 3'b000);
    drv_b(0, 1'b1, 1'b1, 5'd4, 3'b001);
    drv_b(1, 1'b1, 1'b0, 5'd6, 3'b000);
    #1;
    check("rst_rdy0",   32'(a0.ready), 32'd0);
    check("rst_rdy1",   32'(a1.ready), 32'd0);
    check("rst_wren",   32'(wren1), 32'd0);
    check("rst_b_rdy0", 32'(b0.ready), 32'd0);
    check("rst_b_rdy1", 32'(b1.ready), 32'd0);
    check("rst_b_wren", 32'(wren2), 32'd0);
    check("rst_rspv0",  32'(a0.rsp_valid), 32'd0);
    check("rst_rspd0",  32'(a0.rsp_data), 32'd0);
    check("rst_rspv1",  32'(a1.rsp_valid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    load  = 1'b0;
    drv_b(0, 1'b0, 1'b0, 5'd0, 3'b000);
    drv_b(1, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    // 2: first contest goes to port 0 (write 5 = 101)
    check("first_rdy0", 32'(a0.ready), 32'd1);
    check("first_rdy1", 32'(a1.ready), 32'd0);
    check("first_wren", 32'(wren1), 32'd1);
    check("first_addr", 32'(addr1), 32'd5);
    tick();
    drv_a(0, 1'b1, 1'b0, 5'd5, 3'b000);
    #1;
    check("t2_rdy1", 32'(a1.ready), 32'd1);
    check("t2_rdy0", 32'(a0.ready), 32'd0);
    tick();
    drv_a(1, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    check("t2_rspv1", 32'(a1.rsp_valid), 32'd1);
    check("t2_rspd1", 32'(a1.rsp_data), 32'(f1(2)));
    check("t2_rspv0", 32'(a0.rsp_valid), 32'd0);
    check("t2_rdy0b", 32'(a0.ready), 32'd1);
    tick();
    drv_a(0, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    check("t2_rspv0b", 32'(a0.rsp_valid), 32'd1);
    check("t2_rspd0b", 32'(a0.rsp_data), 32'd5);
    check("t2_rspv1b", 32'(a1.rsp_valid), 32'd0);
    tick();
    check("t2_idle_v", 32'(a0.rsp_valid), 32'd0);
    check("t2_idle_d", 32'(a0.rsp_data), 32'd0);

    // 3: continuous contention; port 0 was granted last, so port 1 goes first
    drv_a(0, 1'b1, 1'b0, 5'd1, 3'b000);
    drv_a(1, 1'b1, 1'b0, 5'd2, 3'b000);
    prev_g = -1;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 1 : 0;
      #1;
      check("t3_rdy0", 32'(a0.ready), (exp_g == 0) ? 32'd1 : 32'd0);
      check("t3_rdy1", 32'(a1.ready), (exp_g == 1) ? 32'd1 : 32'd0);
      if (prev_g == 0) begin
        check("t3_rspv0", 32'(a0.rsp_valid), 32'd1);
        check("t3_rspd0", 32'(a0.rsp_data), 32'(f1(1)));
        check("t3_rspv1", 32'(a1.rsp_valid), 32'd0);
      end else if (prev_g == 1) begin
        check("t3_rspv1", 32'(a1.rsp_valid), 32'd1);
        check("t3_rspd1", 32'(a1.rsp_data), 32'(f1(2)));
        check("t3_rspv0", 32'(a0.rsp_valid), 32'd0);
      end
      prev_g = exp_g;
      tick();
    end
    drv_a(0, 1'b0, 1'b0, 5'd0, 3'b000);
    drv_a(1, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    check("t3_last_v0", 32'(a0.rsp_valid), 32'd1);
    check("t3_last_d0", 32'(a0.rsp_data), 32'(f1(1)));
    tick();

    // 4: read and write to addr 31 collide right after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv_a(0, 1'b1, 1'b0, 5'd31, 3'b000);
    drv_a(1, 1'b1, 1'b1, 5'd31, 3'b111);
    #1;
    check("t4_rdy0", 32'(a0.ready), 32'd1);
    check("t4_rdy1", 32'(a1.ready), 32'd0);
    tick();
    #1;
    check("t4_old_v", 32'(a0.rsp_valid), 32'd1);
    check("t4_old_d", 32'(a0.rsp_data), 32'(f1(31)));
    check("t4_wr_rdy1", 32'(a1.ready), 32'd1);
    check("t4_wr_wren", 32'(wren1), 32'd1);
    tick();
    drv_a(1, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    check("t4_rd_rdy0", 32'(a0.ready), 32'd1);
    tick();
    drv_a(0, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    check("t4_new_v", 32'(a0.rsp_valid), 32'd1);
    check("t4_new_d", 32'(a0.rsp_data), 32'd7);
    tick();

    // 5: reset while a read is still in flight on the two-cycle build
    drv_b(0, 1'b1, 1'b0, 5'd3, 3'b000);
    #1;
    check("t5_rdy0", 32'(b0.ready), 32'd1);
    tick();
    drv_b(0, 1'b0, 1'b0, 5'd0, 3'b000);
    reset = 1'b1;
    #1;
    check("t5_kill_a", 32'(b0.rsp_valid), 32'd0);
    tick();
    check("t5_kill_b", 32'(b0.rsp_valid), 32'd0);
    reset = 1'b0;
    tick();
    check("t5_kill_c", 32'(b0.rsp_valid), 32'd0);
    check("t5_kill_c1", 32'(b1.rsp_valid), 32'd0);
    drv_b(0, 1'b1, 1'b0, 5'd3, 3'b000);
    #1;
    check("t5_fresh_rdy", 32'(b0.ready), 32'd1);
    tick();
    drv_b(0, 1'b0, 1'b0, 5'd0, 3'b000);
    #1;
    check("t5_early", 32'(b0.rsp_valid), 32'd0);
    tick();
    check("t5_fresh_v", 32'(b0.rsp_valid), 32'd1);
    check("t5_fresh_d", 32'(b0.rsp_data), 32'(f2(3)));
    tick();

    // 6: three back-to-back port 1 reads with two-cycle latency
    for (int k = 0; k < 3; k++) begin
      drv_b(1, 1'b1, 1'b0, 5'(k), 3'b000);
      #1;
      check("t6_rdy1", 32'(b1.ready), 32'd1);
      if (k < 2) check("t6_not_yet", 32'(b1.rsp_valid), 32'd0);
      else begin
        check("t6_rspv", 32'(b1.rsp_valid), 32'd1);
        check("t6_rspd", 32'(b1.rsp_data), 32'(f2(0)));
      end
      tick();
    end
    drv_b(1, 1'b0, 1'b0, 5'd0, 3'b000);
    for (int k = 1; k < 3; k++) begin
      #1;
      check("t6_rspv", 32'(b1.rsp_valid), 32'd1);
      check("t6_rspd", 32'(b1.rsp_data), 32'(f2(k)));
      check("t6_rspv0", 32'(b0.rsp_valid), 32'd0);
      tick();
    end
    check("t6_done", 32'(b1.rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
